// File: rtl/box_motion_ctrl.sv
// box_motion_ctrl: frame-synchronous position controller for the bouncing-box renderer.
// The box advances once every FRAME_DIV accepted frame_start pulses. It clamps and
// reverses direction at the edges of the drawable area.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous, active-high reset
//   frame_start  1-cycle pulse at start of vertical blank
//   enable       1 = accept frame_start; 0 = hold position (an update in flight completes)
//   box_x/box_y  published top-left corner, stable outside the commit cycle
//   pos_valid    1-cycle pulse in the cycle box_x/box_y take their new value
//   busy         high while an update is in CALC or COMMIT
//   hit_count    (only with BOX_MOTION_HIT_CNT_EN) number of updates with a direction flip
//
// Optional feature macro: BOX_MOTION_HIT_CNT_EN adds the hit_count output and its counter.
module box_motion_ctrl #(
  parameter int unsigned BOX_W     = 50,
  parameter int unsigned BOX_H     = 50,
  parameter int unsigned AREA_W    = 640,
  parameter int unsigned AREA_H    = 480,
  parameter int unsigned X_SPEED   = 1,
  parameter int unsigned Y_SPEED   = 1,
  parameter int unsigned FRAME_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        enable,
  output logic [15:0] box_x,
  output logic [15:0] box_y,
  output logic        pos_valid,
`ifdef BOX_MOTION_HIT_CNT_EN
  output logic [15:0] hit_count,
`endif
  output logic        busy
);

  if (AREA_W <= BOX_W) begin : g_bad_w
    $error("box_motion_ctrl: AREA_W must exceed BOX_W");
  end
  if (AREA_H <= BOX_H) begin : g_bad_h
    $error("box_motion_ctrl: AREA_H must exceed BOX_H");
  end
  if (FRAME_DIV == 0) begin : g_bad_div
    $error("box_motion_ctrl: FRAME_DIV must be at least 1");
  end

  // 17-bit so that pos + speed can never wrap before the limit compare.
  localparam logic [16:0] LimX = 17'(AREA_W - BOX_W);
  localparam logic [16:0] LimY = 17'(AREA_H - BOX_H);
  localparam logic [16:0] SpdX = 17'(X_SPEED);
  localparam logic [16:0] SpdY = 17'(Y_SPEED);

  localparam int unsigned CntW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FRAME_DIV - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StCommit} state_e;

  typedef struct packed {
    logic [15:0] pos;
    logic        fwd;
    logic        flip;
  } axis_t;

  // One bounce step on a single axis; fwd=1 means moving towards the far edge.
  function automatic axis_t axis_next(input logic [15:0] pos, input logic fwd,
                                      input logic [16:0] spd, input logic [16:0] lim);
    axis_t r;
    logic [16:0] ext;
    logic [16:0] sum;
    ext    = {1'b0, pos};
    sum    = ext + spd;
    r.pos  = pos;
    r.fwd  = fwd;
    r.flip = 1'b0;
    if (spd != 17'd0) begin
      if (fwd) begin
        if (sum >= lim) begin
          r.pos  = lim[15:0];
          r.fwd  = 1'b0;
          r.flip = 1'b1;
        end else begin
          r.pos = sum[15:0];
        end
      end else begin
        if (ext <= spd) begin
          r.pos  = 16'd0;
          r.fwd  = 1'b1;
          r.flip = 1'b1;
        end else begin
          r.pos = pos - spd[15:0];
        end
      end
    end
    return r;
  endfunction

  state_e         state_q, state_d;
  logic [CntW-1:0] frame_cnt_q, frame_cnt_d;
  logic [15:0]    box_x_q, box_y_q;
  logic           dir_x_q, dir_y_q;
  axis_t          nxt_x, nxt_y;

  always_comb begin
    nxt_x = axis_next(box_x_q, dir_x_q, SpdX, LimX);
    nxt_y = axis_next(box_y_q, dir_y_q, SpdY, LimY);
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start && enable) begin
          if (frame_cnt_q == CntMax) begin
            frame_cnt_d = '0;
            state_d     = StCalc;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      StCalc:   state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // The computed step is registered on the CALC->COMMIT edge, so the new position and
  // pos_valid are visible together for the whole COMMIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      frame_cnt_q <= '0;
      box_x_q     <= '0;
      box_y_q     <= '0;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      if (state_q == StCalc) begin
        box_x_q <= nxt_x.pos;
        box_y_q <= nxt_y.pos;
        dir_x_q <= nxt_x.fwd;
        dir_y_q <= nxt_y.fwd;
      end
    end
  end

`ifdef BOX_MOTION_HIT_CNT_EN
  logic [15:0] hit_cnt_q;

  // A corner hit flips both axes but counts as a single hit; wraps naturally at 0xFFFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q <= '0;
    end else if (state_q == StCalc && (nxt_x.flip || nxt_y.flip)) begin
      hit_cnt_q <= hit_cnt_q + 16'd1;
    end
  end

  assign hit_count = hit_cnt_q;
`endif

  assign box_x     = box_x_q;
  assign box_y     = box_y_q;
  assign pos_valid = (state_q == StCommit);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_box_motion_ctrl.sv
module tb_box_motion_ctrl;

  localparam int LIM_X = 590;
  localparam int LIM_Y = 430;
  localparam int N     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic enable = 1'b1;

  always #5 clk = ~clk;

  logic [15:0] bx [N];
  logic [15:0] by [N];
  logic        pv [N];
  logic        bz [N];
`ifdef BOX_MOTION_HIT_CNT_EN
  logic [15:0] hc [N];
`endif

  // Instance 0: defaults; 1: X_SPEED=7, Y_SPEED=3; 2: FRAME_DIV=3.
  box_motion_ctrl u_def (
    .clk(clk), .rst(rst), .frame_start(frame_start), .enable(enable),
    .box_x(bx[0]), .box_y(by[0]), .pos_valid(pv[0]),
`ifdef BOX_MOTION_HIT_CNT_EN
    .hit_count(hc[0]),
`endif
    .busy(bz[0])
  );

  box_motion_ctrl #(.X_SPEED(7), .Y_SPEED(3)) u_fast (
    .clk(clk), .rst(rst), .frame_start(frame_start), .enable(enable),
    .box_x(bx[1]), .box_y(by[1]), .pos_valid(pv[1]),
`ifdef BOX_MOTION_HIT_CNT_EN
    .hit_count(hc[1]),
`endif
    .busy(bz[1])
  );

  box_motion_ctrl #(.FRAME_DIV(3)) u_div (
    .clk(clk), .rst(rst), .frame_start(frame_start), .enable(enable),
    .box_x(bx[2]), .box_y(by[2]), .pos_valid(pv[2]),
`ifdef BOX_MOTION_HIT_CNT_EN
    .hit_count(hc[2]),
`endif
    .busy(bz[2])
  );

  int total = 0;
  int bad   = 0;

  // Reference model: per-instance position, direction, frame count, and cycles left in update.
  int spx  [N] = '{1, 7, 1};
  int spy  [N] = '{1, 3, 1};
  int sdiv [N] = '{1, 1, 3};
  int mx [N];
  int my [N];
  bit mfx [N];
  bit mfy [N];
  int mcnt [N];
  int mleft [N];
  bit mpv [N];
  int mhit [N];

  function automatic void axis(input int pos, input bit fwd, input int spd, input int lim,
                               output int npos, output bit nfwd, output bit flip);
    npos = pos;
    nfwd = fwd;
    flip = 1'b0;
    if (spd == 0) return;
    if (fwd) begin
      if (pos + spd >= lim) begin
        npos = lim; nfwd = 1'b0; flip = 1'b1;
      end else begin
        npos = pos + spd;
      end
    end else begin
      if (pos <= spd) begin
        npos = 0; nfwd = 1'b1; flip = 1'b1;
      end else begin
        npos = pos - spd;
      end
    end
  endfunction

  function automatic void model_edge(input bit fs, input bit en, input bit r);
    for (int i = 0; i < N; i++) begin
      if (r) begin
        mx[i] = 0; my[i] = 0; mfx[i] = 1'b1; mfy[i] = 1'b1;
        mcnt[i] = 0; mleft[i] = 0; mpv[i] = 1'b0; mhit[i] = 0;
      end else begin
        mpv[i] = 1'b0;
        if (mleft[i] == 2) begin
          int nx, ny;
          bit fx, fy, hx, hy;
          axis(mx[i], mfx[i], spx[i], LIM_X, nx, fx, hx);
          axis(my[i], mfy[i], spy[i], LIM_Y, ny, fy, hy);
          mx[i] = nx; my[i] = ny; mfx[i] = fx; mfy[i] = fy;
          if (hx || hy) mhit[i] = (mhit[i] + 1) % 65536;
          mpv[i] = 1'b1;
          mleft[i] = 1;
        end else if (mleft[i] == 1) begin
          mleft[i] = 0;
        end else if (fs && en) begin
          mcnt[i]++;
          if (mcnt[i] == sdiv[i]) begin
            mcnt[i] = 0;
            mleft[i] = 2;
          end
        end
      end
    end
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, return at the falling edge.
  task automatic step(input bit fs, input bit en, input bit r);
    frame_start = fs;
    enable      = en;
    rst         = r;
    @(posedge clk);
    model_edge(fs, en, r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
  endtask

  // One frame_start followed by idle cycles, long enough for the update to finish.
  task automatic one_update(input int gap);
    step(1'b1, 1'b1, 1'b0);
    for (int k = 1; k < gap; k++) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 100; c++) begin
      step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < N; i++) begin
        total++;
        if ({bx[i], by[i], pv[i], bz[i]} !== 34'd0) begin
          bad++;
          $display("FAIL reset_idle inst=%0d cyc=%0d got x=%0d y=%0d pv=%b busy=%b want all 0",
                   i, c, bx[i], by[i], pv[i], bz[i]);
        end
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    total++;
    if ({bz[0], pv[0]} !== 2'b10) begin
      bad++;
      $display("FAIL single_t1 got busy=%b pv=%b want busy=1 pv=0", bz[0], pv[0]);
    end
    step(1'b0, 1'b1, 1'b0);
    total++;
    if ({bz[0], pv[0], bx[0], by[0]} !== {1'b1, 1'b1, 16'd1, 16'd1}) begin
      bad++;
      $display("FAIL single_t2 got busy=%b pv=%b x=%0d y=%0d want 1 1 1 1",
               bz[0], pv[0], bx[0], by[0]);
    end
    step(1'b0, 1'b1, 1'b0);
    total++;
    if ({bz[0], pv[0], bx[0], by[0]} !== {1'b0, 1'b0, 16'd1, 16'd1}) begin
      bad++;
      $display("FAIL single_t3 got busy=%b pv=%b x=%0d y=%0d want 0 0 1 1",
               bz[0], pv[0], bx[0], by[0]);
    end
  endtask

  task automatic test_enable();
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0);
      total++;
      if ({bz[0], pv[0], bx[0], by[0]} !== 34'd0) begin
        bad++;
        $display("FAIL enable_off got busy=%b pv=%b x=%0d y=%0d want all 0",
                 bz[0], pv[0], bx[0], by[0]);
      end
    end
  endtask

  task automatic test_x_speed();
    do_reset();
    for (int u = 1; u <= 86; u++) begin
      one_update(3);
      if (u == 84 || u == 85 || u == 86) begin
        int want;
        want = (u == 84) ? 588 : (u == 85) ? 590 : 583;
        total++;
        if (bx[1] !== 16'(want)) begin
          bad++;
          $display("FAIL x_speed7 update=%0d got x=%0d want %0d", u, bx[1], want);
        end
      end
    end
  endtask

  task automatic test_y_bounce();
    do_reset();
    for (int u = 1; u <= 431; u++) begin
      one_update(3);
      if (u == 430) begin
        total++;
        if (by[0] !== 16'd430) begin
          bad++;
          $display("FAIL y_flip got y=%0d want 430", by[0]);
        end
`ifdef BOX_MOTION_HIT_CNT_EN
        total++;
        if (hc[0] !== 16'd1) begin
          bad++;
          $display("FAIL hit_count got %0d want 1", hc[0]);
        end
`endif
      end
      if (u == 431) begin
        total++;
        if (by[0] !== 16'd429) begin
          bad++;
          $display("FAIL y_back got y=%0d want 429", by[0]);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if ({bx[i], by[i]} !== {16'(mx[i]), 16'(my[i])}) begin
        bad++;
        $display("FAIL y_bounce_model inst=%0d got (%0d,%0d) want (%0d,%0d)",
                 i, bx[i], by[i], mx[i], my[i]);
      end
    end
  endtask

  task automatic test_frame_div();
    do_reset();
    for (int f = 1; f <= 6; f++) begin
      int pulses;
      int want;
      pulses = 0;
      step(1'b1, 1'b1, 1'b0);
      pulses += int'(pv[2]);
      for (int k = 1; k < 10; k++) begin
        step(1'b0, 1'b1, 1'b0);
        pulses += int'(pv[2]);
      end
      want = (f % 3 == 0) ? 1 : 0;
      total++;
      if (pulses != want) begin
        bad++;
        $display("FAIL frame_div_pulses fs=%0d got %0d want %0d", f, pulses, want);
      end
    end
    total++;
    if ({bx[2], by[2]} !== {16'd2, 16'd2}) begin
      bad++;
      $display("FAIL frame_div_final got (%0d,%0d) want (2,2)", bx[2], by[2]);
    end
  endtask

  task automatic test_back_to_back_reset();
    int pulses;
    do_reset();
    pulses = 0;
    step(1'b1, 1'b1, 1'b0);
    pulses += int'(pv[0]);
    step(1'b1, 1'b1, 1'b0);
    pulses += int'(pv[0]);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b0);
      pulses += int'(pv[0]);
    end
    total++;
    if (pulses != 1 || bx[0] !== 16'd1) begin
      bad++;
      $display("FAIL b2b_single_update got pulses=%0d x=%0d want 1 1", pulses, bx[0]);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) begin
        total++;
        if ({bx[i], by[i], pv[i], bz[i]} !== 34'd0) begin
          bad++;
          $display("FAIL abort_reset inst=%0d cyc=%0d got x=%0d y=%0d pv=%b busy=%b want 0",
                   i, k, bx[i], by[i], pv[i], bz[i]);
        end
`ifdef BOX_MOTION_HIT_CNT_EN
        total++;
        if (hc[i] !== 16'd0) begin
          bad++;
          $display("FAIL abort_hit inst=%0d got %0d want 0", i, hc[i]);
        end
`endif
      end
      step(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit fs, en, r;
      fs = ($urandom_range(0, 3) == 0);
      en = ($urandom_range(0, 4) != 0);
      r  = ($urandom_range(0, 499) == 0);
      step(fs, en, r);
      for (int i = 0; i < N; i++) begin
        total++;
        if ({bx[i], by[i], pv[i], bz[i]} !==
            {16'(mx[i]), 16'(my[i]), mpv[i], (mleft[i] != 0)}) begin
          bad++;
          $display("FAIL random inst=%0d cyc=%0d got x=%0d y=%0d pv=%b busy=%b want %0d %0d %b %b",
                   i, c, bx[i], by[i], pv[i], bz[i], mx[i], my[i], mpv[i], mleft[i] != 0);
        end
`ifdef BOX_MOTION_HIT_CNT_EN
        total++;
        if (hc[i] !== 16'(mhit[i])) begin
          bad++;
          $display("FAIL random_hit inst=%0d cyc=%0d got %0d want %0d", i, c, hc[i], mhit[i]);
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_enable();
    test_x_speed();
    test_y_bounce();
    test_frame_div();
    test_back_to_back_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
